// File: rtl/loop_stream_ctrl.sv
// Loop-stream controller: captures a short backward-branch loop body coming out of
// fetch, then replays it to ID from a local buffer while fetch is held.
//
// state      | meaning
// S_IDLE     | passthrough, watching for a short backward conditional branch
// S_ARM      | loop candidate latched, waiting for fetch to reach the loop target
// S_CAPTURE  | passthrough, writing the sequential loop body into the buffer
// S_REPLAY   | fetch blocked, ID fed from the buffer, iterations counted
// S_EXIT     | one-cycle flush with redirect to the loop fall-through
module loop_stream_ctrl #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       curr_PC,
   input  logic [31:0]       instruction,
   input  logic [31:0]       immediate,
   input  logic              mispredict,
   input  logic              bubble_idex,
   output logic              block_signal,
   output logic              flush,
   output logic [31:0]       new_pc,
   output logic [31:0]       out_instruction,
   output logic              loop_active,
   output logic [CNT_W-1:0]  iter_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_CAPTURE,
      S_REPLAY,
      S_EXIT
   } state_t;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   state_t            state_q, state_d;
   logic [31:0]       br_pc_q, br_pc_d;
   logic [31:0]       tgt_pc_q, tgt_pc_d;
   logic [31:0]       prev_pc_q, prev_pc_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  iter_q, iter_d;
   logic              flush_q, flush_d;
   logic [31:0]       new_pc_q, new_pc_d;

   logic [31:0]       loop_buf_q [DEPTH];
   logic              buf_we;
   logic [ADDR_W-1:0] buf_widx;

   logic              is_branch, is_ctrl, is_bb, in_range, seq_ok, at_last;
   logic [31:0]       neg_imm, body_len, bb_tgt;
   logic [ADDR_W:0]   bb_len, last_idx;
   logic [ADDR_W-1:0] cap_idx;

   assign is_branch = (instruction[6:0] == OP_BRANCH);
   assign is_ctrl   = is_branch || (instruction[6:0] == OP_JAL) || (instruction[6:0] == OP_JALR);
   assign neg_imm   = 32'd0 - immediate;
   assign body_len  = (neg_imm >> 2) + 32'd1;
   assign is_bb     = is_branch && immediate[31] && (body_len <= 32'(DEPTH));
   assign bb_tgt    = curr_PC + immediate;
   assign bb_len    = (ADDR_W+1)'(body_len);
   assign in_range  = (curr_PC >= tgt_pc_q) && (curr_PC <= br_pc_q);
   assign seq_ok    = (curr_PC == prev_pc_q + 32'd4);
   assign cap_idx   = ADDR_W'((curr_PC - tgt_pc_q) >> 2);
   assign last_idx  = len_q - (ADDR_W+1)'(1);
   assign at_last   = ({1'b0, rd_ptr_q} == last_idx);

   always_comb begin
      state_d   = state_q;
      br_pc_d   = br_pc_q;
      tgt_pc_d  = tgt_pc_q;
      prev_pc_d = prev_pc_q;
      len_d     = len_q;
      rd_ptr_d  = rd_ptr_q;
      iter_d    = iter_q;
      flush_d   = 1'b0;
      new_pc_d  = '0;
      buf_we    = 1'b0;
      buf_widx  = cap_idx;
      case (state_q)
         S_IDLE: begin
            if (is_bb) begin
               br_pc_d  = curr_PC;
               tgt_pc_d = bb_tgt;
               len_d    = bb_len;
               state_d  = S_ARM;
            end
         end
         S_ARM: begin
            if (mispredict) begin
               state_d = S_IDLE;
            end else if (curr_PC == tgt_pc_q) begin
               if (!bubble_idex) begin
                  buf_we    = 1'b1;
                  buf_widx  = '0;
                  prev_pc_d = curr_PC;
                  iter_d    = '0;
                  state_d   = S_CAPTURE;
               end
            end else if (is_bb && (curr_PC != br_pc_q)) begin
               br_pc_d  = curr_PC;
               tgt_pc_d = bb_tgt;
               len_d    = bb_len;
            end else if (!in_range) begin
               state_d = S_IDLE;
            end
         end
         S_CAPTURE: begin
            // bubble cycles repeat the previous fetch, so they neither write nor abort
            if (mispredict) begin
               state_d = S_IDLE;
            end else if (!bubble_idex) begin
               if (!seq_ok || !in_range || (is_ctrl && (curr_PC != br_pc_q))) begin
                  state_d = S_IDLE;
               end else begin
                  buf_we    = 1'b1;
                  prev_pc_d = curr_PC;
                  if ((curr_PC == br_pc_q) && is_branch) begin
                     rd_ptr_d = '0;
                     state_d  = S_REPLAY;
                  end
               end
            end
         end
         S_REPLAY: begin
            if (mispredict) begin
               flush_d  = 1'b1;
               new_pc_d = br_pc_q + 32'd4;
               state_d  = S_EXIT;
            end else if (!bubble_idex) begin
               if (at_last) begin
                  rd_ptr_d = '0;
                  if (iter_q != '1) iter_d = iter_q + CNT_W'(1);
               end else begin
                  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
               end
            end
         end
         S_EXIT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         br_pc_q   <= '0;
         tgt_pc_q  <= '0;
         prev_pc_q <= '0;
         len_q     <= '0;
         rd_ptr_q  <= '0;
         iter_q    <= '0;
         flush_q   <= 1'b0;
         new_pc_q  <= '0;
      end else begin
         state_q   <= state_d;
         br_pc_q   <= br_pc_d;
         tgt_pc_q  <= tgt_pc_d;
         prev_pc_q <= prev_pc_d;
         len_q     <= len_d;
         rd_ptr_q  <= rd_ptr_d;
         iter_q    <= iter_d;
         flush_q   <= flush_d;
         new_pc_q  <= new_pc_d;
      end
   end

   // buffer contents are don't-care after reset, so the storage carries no reset
   always_ff @(posedge clk) begin
      if (buf_we) loop_buf_q[buf_widx] <= instruction;
   end

   always_comb begin
      out_instruction = instruction;
      if (!reset)                    out_instruction = '0;
      else if (state_q == S_REPLAY)  out_instruction = loop_buf_q[rd_ptr_q];
   end

   assign block_signal = (state_q == S_REPLAY);
   assign loop_active  = (state_q == S_REPLAY);
   assign flush        = flush_q;
   assign new_pc       = new_pc_q;
   assign iter_count   = iter_q;

endmodule

// File: tb/tb_loop_stream_ctrl.sv
// Bench for loop_stream_ctrl: directed loop scenarios plus randomized loops, checked
// every cycle against a behavioural model of capture and replay.
module tb_loop_stream_ctrl;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       curr_PC, instruction, immediate;
   logic              mispredict, bubble_idex;
   logic              block_signal, flush, loop_active;
   logic [31:0]       new_pc, out_instruction;
   logic [CNT_W-1:0]  iter_count;

   loop_stream_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .curr_PC         (curr_PC),
      .instruction     (instruction),
      .immediate       (immediate),
      .mispredict      (mispredict),
      .bubble_idex     (bubble_idex),
      .block_signal    (block_signal),
      .flush           (flush),
      .new_pc          (new_pc),
      .out_instruction (out_instruction),
      .loop_active     (loop_active),
      .iter_count      (iter_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // behavioural model: loop body kept by word offset, replay tracked as a count of advances
   localparam int M_IDLE = 0, M_ARM = 1, M_CAP = 2, M_REP = 3, M_EXIT = 4;
   int           m_mode;
   logic [31:0]  m_br, m_tgt, m_last;
   int           m_arm_len, m_len;
   longint       m_adv;
   logic [31:0]  m_body [int];

   logic [31:0]  body_words [32];
   logic [31:0]  obs_out, obs_newpc;
   logic         obs_block, obs_flush;
   logic [31:0]  obs_iter;

   function automatic bit is_loop_branch(input logic [31:0] ins, input logic [31:0] imm);
      longint s;
      s = longint'($signed(imm));
      return (ins[6:0] == 7'h63) && (s < 0) && (((-s) / 4 + 1) <= DEPTH);
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE;
      m_br = 0; m_tgt = 0; m_last = 0;
      m_arm_len = 1; m_len = 1; m_adv = 0;
      m_body.delete();
   endtask

   task automatic model_arm(input logic [31:0] pc, input logic [31:0] imm);
      m_br      = pc;
      m_tgt     = pc + imm;
      m_arm_len = int'((-longint'($signed(imm))) / 4 + 1);
      m_mode    = M_ARM;
   endtask

   task automatic model_step(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] imm,
                             input logic mis, input logic bub);
      bit ctrl;
      ctrl = (ins[6:0] == 7'h63) || (ins[6:0] == 7'h6F) || (ins[6:0] == 7'h67);
      case (m_mode)
         M_IDLE: if (is_loop_branch(ins, imm)) model_arm(pc, imm);
         M_ARM: begin
            if (mis) m_mode = M_IDLE;
            else if (pc == m_tgt) begin
               if (!bub) begin
                  m_body.delete();
                  m_body[0] = ins;
                  m_len  = m_arm_len;
                  m_adv  = 0;
                  m_last = pc;
                  m_mode = M_CAP;
               end
            end else if (is_loop_branch(ins, imm) && pc != m_br) model_arm(pc, imm);
            else if (pc < m_tgt || pc > m_br) m_mode = M_IDLE;
         end
         M_CAP: begin
            if (mis) m_mode = M_IDLE;
            else if (!bub) begin
               if (pc != m_last + 32'd4 || pc < m_tgt || pc > m_br || (ctrl && pc != m_br))
                  m_mode = M_IDLE;
               else begin
                  m_body[int'((pc - m_tgt) / 4)] = ins;
                  m_last = pc;
                  if (pc == m_br && ins[6:0] == 7'h63) m_mode = M_REP;
               end
            end
         end
         M_REP: begin
            if (mis) m_mode = M_EXIT;
            else if (!bub) m_adv++;
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic check_outputs();
      logic [31:0] e_out, e_np;
      logic        e_rep, e_fl;
      longint      e_it;
      if (!reset) begin
         e_out = 0; e_np = 0; e_rep = 0; e_fl = 0; e_it = 0;
      end else begin
         e_rep = (m_mode == M_REP);
         e_fl  = (m_mode == M_EXIT);
         e_np  = e_fl ? (m_br + 32'd4) : 32'd0;
         e_out = e_rep ? m_body[int'(m_adv % m_len)] : instruction;
         e_it  = m_adv / m_len;
         if (e_it > 65535) e_it = 65535;
      end
      check_eq("block_signal", {31'd0, block_signal}, {31'd0, e_rep});
      check_eq("loop_active", {31'd0, loop_active}, {31'd0, e_rep});
      check_eq("flush", {31'd0, flush}, {31'd0, e_fl});
      check_eq("new_pc", new_pc, e_np);
      check_eq("out_instruction", out_instruction, e_out);
      check_eq("iter_count", {16'd0, iter_count}, 32'(e_it));
      obs_out = out_instruction; obs_newpc = new_pc; obs_block = block_signal;
      obs_flush = flush; obs_iter = {16'd0, iter_count};
   endtask

   task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] imm,
                       input logic mis, input logic bub);
      curr_PC = pc; instruction = ins; immediate = imm; mispredict = mis; bubble_idex = bub;
      @(negedge clk);
      check_outputs();
      if (!reset) model_reset();
      else        model_step(pc, ins, imm, mis, bub);
      @(posedge clk);
      #1;
   endtask

   task automatic replay_step(input logic mis, input logic bub);
      step(32'h0000_0FF0, 32'h0000_0033, 32'd0, mis, bub);
   endtask

   task automatic run_pass(input logic [31:0] base, input int len, input int bub_pct,
                           input int jal_pos, input int mis_pos);
      for (int i = 0; i < len; i++) begin
         logic [31:0] pc, ins, imm;
         pc  = base + 32'(4 * i);
         ins = (i == jal_pos) ? 32'h0000_006F : body_words[i];
         imm = (i == len - 1) ? (32'd0 - 32'(4 * (len - 1))) : 32'd0;
         while ($urandom_range(99) < bub_pct) step(pc, ins, imm, 1'b0, 1'b1);
         step(pc, ins, imm, (i == mis_pos), 1'b0);
      end
   endtask

   task automatic load_small_loop();
      body_words[0] = 32'h0000_0013;
      body_words[1] = 32'h0000_0014;
      body_words[2] = 32'h0000_0015;
      body_words[3] = 32'hFC00_0AE3;
   endtask

   task automatic run_random(input int n_loops);
      int          len, jal_pos, mis_pos, n_rep;
      logic [31:0] base, w, br;
      for (int t = 0; t < n_loops; t++) begin
         len  = $urandom_range(2, 10);
         base = 32'h0001_0000 + (32'($urandom_range(0, 16383)) << 2);
         for (int i = 0; i < len; i++) begin
            w = $urandom();
            w[6:0] = (i == len - 1) ? 7'h63 : 7'h13;
            body_words[i] = w;
         end
         jal_pos = (len > 2 && $urandom_range(5) == 0) ? int'($urandom_range(1, len - 2)) : -1;
         mis_pos = ($urandom_range(7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         run_pass(base, len, 20, -1, -1);
         run_pass(base, len, 20, jal_pos, mis_pos);
         br    = base + 32'(4 * (len - 1));
         n_rep = $urandom_range(0, 3 * len + 3);
         for (int k = 0; k < n_rep; k++)
            step(br + 32'd4, 32'h0000_0033, 32'd0, 1'b0, ($urandom_range(3) == 0));
         step(br + 32'd4, 32'h0000_0033, 32'd0, 1'b1, ($urandom_range(1) == 1));
         step(br + 32'd8, 32'h0000_0033, 32'd0, 1'b0, 1'b0);
         step(br + 32'd12, 32'h0000_0013, 32'd0, 1'b0, 1'b0);
      end
   endtask

   logic [31:0] exp_body [4];

   initial begin
      reset = 1'b0;
      curr_PC = 0; instruction = 0; immediate = 0; mispredict = 0; bubble_idex = 0;
      model_reset();
      exp_body[0] = 32'h0000_0013; exp_body[1] = 32'h0000_0014;
      exp_body[2] = 32'h0000_0015; exp_body[3] = 32'hFC00_0AE3;

      repeat (2) begin
         curr_PC = $urandom(); instruction = $urandom(); immediate = $urandom();
         mispredict = 1'($urandom_range(1)); bubble_idex = 1'($urandom_range(1));
         @(negedge clk);
         check_eq("rst_block", {31'd0, block_signal}, 32'd0);
         check_eq("rst_flush", {31'd0, flush}, 32'd0);
         check_eq("rst_active", {31'd0, loop_active}, 32'd0);
         check_eq("rst_new_pc", new_pc, 32'd0);
         check_eq("rst_iter", {16'd0, iter_count}, 32'd0);
         check_eq("rst_out", out_instruction, 32'd0);
         @(posedge clk);
         #1;
      end
      reset = 1'b1;

      // capture and replay of a 4-instruction loop at 0x100
      load_small_loop();
      run_pass(32'h100, 4, 0, -1, -1);
      run_pass(32'h100, 4, 0, -1, -1);
      for (int k = 0; k < 4; k++) begin
         replay_step(1'b0, 1'b0);
         check_eq("replay_out", obs_out, exp_body[k]);
         check_eq("replay_block", {31'd0, obs_block}, 32'd1);
      end
      replay_step(1'b0, 1'b0);
      check_eq("iter_after_4", obs_iter, 32'd1);
      check_eq("replay_wrap_out", obs_out, 32'h0000_0013);
      for (int k = 0; k < 3; k++) begin
         replay_step(1'b0, 1'b1);
         check_eq("stall_out", obs_out, 32'h0000_0014);
         check_eq("stall_iter", obs_iter, 32'd1);
      end
      replay_step(1'b1, 1'b1);
      check_eq("mis_bub_out", obs_out, 32'h0000_0014);
      step(32'h110, 32'h0000_0033, 32'd0, 1'b0, 1'b0);
      check_eq("exit_flush", {31'd0, obs_flush}, 32'd1);
      check_eq("exit_new_pc", obs_newpc, 32'h110);
      check_eq("exit_block", {31'd0, obs_block}, 32'd0);
      step(32'h114, 32'h0050_0093, 32'd0, 1'b0, 1'b0);
      check_eq("post_exit_flush", {31'd0, obs_flush}, 32'd0);
      check_eq("post_exit_new_pc", obs_newpc, 32'd0);
      check_eq("post_exit_pass", obs_out, 32'h0050_0093);
      check_eq("post_exit_iter", obs_iter, 32'd1);

      // second loop at 0x110-0x11C
      run_pass(32'h110, 4, 0, -1, -1);
      run_pass(32'h110, 4, 0, -1, -1);
      repeat (6) replay_step(1'b0, 1'b0);
      replay_step(1'b1, 1'b0);
      step(32'h120, 32'h0000_0033, 32'd0, 1'b0, 1'b0);
      check_eq("exit2_flush", {31'd0, obs_flush}, 32'd1);
      check_eq("exit2_new_pc", obs_newpc, 32'h120);
      step(32'h124, 32'h0000_0013, 32'd0, 1'b0, 1'b0);

      // oversize body is ignored
      for (int i = 0; i < 16; i++) body_words[i] = 32'h0000_0013 + 32'(i << 7);
      body_words[16] = 32'hFC00_0AE3;
      run_pass(32'h1C0, 17, 0, -1, -1);
      run_pass(32'h1C0, 17, 0, -1, -1);
      step(32'h204, 32'h0000_0013, 32'd0, 1'b0, 1'b0);
      check_eq("oversize_block", {31'd0, obs_block}, 32'd0);

      // forward branch is ignored
      step(32'h300, 32'h00C0_0663, 32'd12, 1'b0, 1'b0);
      step(32'h30C, 32'h0000_0013, 32'd0, 1'b0, 1'b0);
      step(32'h310, 32'h0000_0013, 32'd0, 1'b0, 1'b0);
      check_eq("fwd_block", {31'd0, obs_block}, 32'd0);

      // jal inside the body aborts capture
      load_small_loop();
      run_pass(32'h100, 4, 0, -1, -1);
      run_pass(32'h100, 4, 0, 1, -1);
      step(32'h110, 32'h0000_0013, 32'd0, 1'b0, 1'b0);
      check_eq("jal_block", {31'd0, obs_block}, 32'd0);
      check_eq("jal_flush", {31'd0, obs_flush}, 32'd0);

      // mispredict during capture drops back quietly
      run_pass(32'h100, 4, 0, -1, -1);
      run_pass(32'h100, 4, 0, -1, 2);
      step(32'h110, 32'h0000_0013, 32'd0, 1'b0, 1'b0);
      check_eq("capmis_block", {31'd0, obs_block}, 32'd0);
      check_eq("capmis_flush", {31'd0, obs_flush}, 32'd0);

      // asynchronous reset in the third replay cycle
      run_pass(32'h100, 4, 0, -1, -1);
      run_pass(32'h100, 4, 0, -1, -1);
      replay_step(1'b0, 1'b0);
      replay_step(1'b0, 1'b0);
      check_eq("pre_rst_block", {31'd0, obs_block}, 32'd1);
      reset = 1'b0;
      #1;
      check_eq("async_rst_block", {31'd0, block_signal}, 32'd0);
      check_eq("async_rst_active", {31'd0, loop_active}, 32'd0);
      check_eq("async_rst_flush", {31'd0, flush}, 32'd0);
      model_reset();
      step(32'h100, 32'h0000_0013, 32'd0, 1'b0, 1'b0);
      reset = 1'b1;
      run_pass(32'h100, 4, 0, -1, -1);
      run_pass(32'h100, 4, 0, -1, -1);
      for (int k = 0; k < 4; k++) begin
         replay_step(1'b0, 1'b0);
         check_eq("rerun_out", obs_out, exp_body[k]);
      end
      replay_step(1'b1, 1'b0);
      step(32'h110, 32'h0000_0033, 32'd0, 1'b0, 1'b0);
      check_eq("rerun_exit_flush", {31'd0, obs_flush}, 32'd1);
      step(32'h114, 32'h0000_0013, 32'd0, 1'b0, 1'b0);

      run_random(40);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/loop_stream_ctrl.md
Name: loop_stream_ctrl

Overview:
Loop-stream controller that sits between fetch and ID in the RISC-V pipeline. It detects short backward conditional branches and captures the loop body into a small instruction buffer. It then replays the body to ID while blocking fetch. On a mispredict it exits with a flush and a fall-through redirect. It owns the loop buffer storage and sequences its capture, replay and exit.

Parameters:
DEPTH, 8, loop buffer entries (32-bit instructions); power of two
ADDR_W, 3, log2(DEPTH)
CNT_W, 16, iteration counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
curr_PC  in  32  PC of the instruction presented by fetch this cycle
instruction  in  32  fetched instruction
immediate  in  32  sign-extended branch offset from decode, in bytes
mispredict  in  1  branch resolution: loop-closing branch not taken
bubble_idex  in  1  ID/EX stall; hold replay pointer, suppress capture write
block_signal  out  1  stall fetch/PC update (1 only in REPLAY)
flush  out  1  one-cycle pipeline flush on loop exit
new_pc  out  32  redirect target, valid while flush=1
out_instruction  out  32  instruction to ID
loop_active  out  1  1 in REPLAY
iter_count  out  CNT_W  completed replay iterations, saturating

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-low. While reset=0, state=IDLE, pointers=0, buffer contents don't-care, and all outputs are 0.
- Backward branch (bb): instruction[6:0]=7'b1100011, immediate[31]=1, and body_len=((-immediate)>>2)+1 ≤ DEPTH. Otherwise the branch is ignored.
- Registers: br_pc, tgt_pc=curr_PC+immediate, len (ADDR_W+1 bits), wr_idx, rd_ptr, iter_count.
- IDLE:
  - out_instruction=instruction (combinational passthrough).
  - On bb: latch br_pc, tgt_pc and len; go to ARM.
- ARM: passthrough.
  - curr_PC==tgt_pc and !bubble_idex: write buf[0]=instruction; go to CAPTURE.
  - A new bb at a different PC re-arms with the new values.
  - Any other PC outside [tgt_pc, br_pc]: go to IDLE.
- CAPTURE: passthrough. Each non-bubble cycle writes buf[(curr_PC-tgt_pc)>>2]=instruction.
  - curr_PC==br_pc and the instruction is a branch: write it, set rd_ptr=0, go to REPLAY.
  - Abort to IDLE if any of these occurs: PC is non-sequential (≠ previous+4); PC is outside the range; a jal/jalr/branch appears at a PC ≠ br_pc.
- REPLAY:
  - Outputs: block_signal=1, loop_active=1, out_instruction=buf[rd_ptr].
  - rd_ptr advances each cycle unless bubble_idex=1 (hold, same instruction).
  - At rd_ptr==len-1, rd_ptr wraps to 0 and iter_count increments, saturating at all-ones.
  - Replay latency: the first replayed instruction (buf[0]) appears the cycle after the capture of br_pc.
- EXIT (entered from REPLAY on mispredict):
  - Registered outputs for one cycle: flush=1, new_pc=br_pc+4, block_signal=0.
  - Then IDLE; iter_count is held until the next capture.
- mispredict precedence:
  - mispredict has priority over bubble_idex and over wrap.
  - mispredict in ARM or CAPTURE returns to IDLE with no flush; the core redirect handles it.
  - mispredict in IDLE is ignored.
- Defaults: new_pc=0 whenever flush=0. flush is never asserted outside EXIT.
- iter_count clears on entry to CAPTURE.
- Reset asserted mid-REPLAY: block_signal drops immediately (asynchronous); no flush is generated.

Test Plan:
- Reset: reset=0 for 2 cycles with random inputs → block_signal=flush=loop_active=0, new_pc=0, iter_count=0.
- Capture/replay:
  - Stimulus: PCs 0x100/0x104/0x108 with instructions 0x13/0x14/0x15, then 0x10C with 0xFC000AE3 and immediate=-12; repeat the sequence once.
  - Required: ARM after the first 0x10C, CAPTURE at 0x100, REPLAY after the second 0x10C.
  - out_instruction cycles 0x13,0x14,0x15,0xFC000AE3; block_signal=1; iter_count=1 after 4 replay cycles.
- Exit: mispredict=1 during REPLAY → next cycle flush=1, new_pc=0x110 for exactly one cycle, then IDLE and passthrough restored. Repeat at 0x110–0x11C → new_pc=0x120.
- Stall: bubble_idex=1 for 3 cycles mid-replay → out_instruction held constant and rd_ptr/iter_count frozen; mispredict in the same cycle as bubble still exits.
- Oversize/illegal:
  - immediate=-64 (body 17 > 8) → stays IDLE.
  - immediate=+12 → ignored.
  - A jal (opcode 0x6F) at 0x104 during CAPTURE → IDLE, no flush.
- Reset mid-replay: reset=0 at replay cycle 3 → block_signal=0 asynchronously; after release, the loop re-captures from ARM.
